// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial BCD add sequencer driving an external digit adder
// Optional subtract mode: define BCD_SUB_EN to add the op_sub input.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                op_sub,
`endif
  input  logic [4*DIGITS-1:0] op_a,
  input  logic [4*DIGITS-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_cin,
  input  logic [3:0]          add_res,
  input  logic                add_cout
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  a_sh, b_sh;
  logic          carry;
  logic [IW-1:0] idx;
  logic          sub_in;

`ifdef BCD_SUB_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
`endif

  // True when any nibble of the operand is not a decimal digit
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Nine's complement per digit; subtraction then becomes A + ~B + 1
  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and combinational outputs; adder inputs are parked at 0 outside RUN
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy    = 1'b1;
        add_a   = a_sh[3:0];
        add_b   = b_sh[3:0];
        add_cin = carry;
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, per-digit result collection and carry chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= op_a;
          b_sh  <= sub_in ? nines(op_b) : op_b;
          carry <= sub_in | cin;
          idx   <= '0;
          sum   <= '0;
          cout  <= 1'b0;
          err   <= has_bad_digit(op_a) | has_bad_digit(op_b);
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= add_res;
          carry <= add_cout;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          // cout is captured on the last digit so it is already valid while done is high
          if (idx == LAST) cout <= add_cout;
          else             idx  <= idx + 1'b1;
        end
        DONE: cout <= carry;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - scoreboard bench for bcd_serial_add_ctrl with random BCD operands
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;
  logic [3:0]   add_a, add_b, add_res;
  logic         add_cin, add_cout;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .cin(cin),
`ifdef BCD_SUB_EN
    .op_sub(op_sub),
`endif
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_res(add_res), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // External decimal digit adder
  logic [4:0] s5, t5;
  always_comb begin
    s5 = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    t5 = s5 + 5'd6;
    if (s5 > 5'd9) begin
      add_res  = t5[3:0];
      add_cout = 1'b1;
    end else begin
      add_res  = s5[3:0];
      add_cout = 1'b0;
    end
  end

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0, bad = 0;
  int   done_cnt = 0, exp_dones = 0, timeouts = 0;
  bit   fin_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal arithmetic for legal operands, digit rules for illegal ones
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint va = 0, vb = 0, p = 1, r;
    bit     badd = 0;
    int     c, s, da, db;
    for (int i = 0; i < DIGITS; i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) badd = 1;
      va += longint'(da) * p;
      vb += longint'(db) * p;
      p  *= 10;
    end
    e.err = badd;
    e.sum = '0;
    e.cyc = 0;
    if (!badd) begin
      if (sb) begin
        r = va - vb;
        e.cout = (r >= 0);
        if (r < 0) r += p;
      end else begin
        r = va + vb + longint'(ci);
        e.cout = (r >= p);
        if (r >= p) r -= p;
      end
      for (int i = 0; i < DIGITS; i++) begin
        e.sum[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end else begin
      c = sb ? 1 : int'(ci);
      for (int i = 0; i < DIGITS; i++) begin
        da = int'(a[4*i +: 4]);
        db = int'(b[4*i +: 4]);
        if (sb) db = (9 - db) & 15;
        s = da + db + c;
        if (s > 9) begin
          e.sum[4*i +: 4] = 4'((s + 6) & 15);
          c = 1;
        end else begin
          e.sum[4*i +: 4] = 4'(s);
          c = 0;
        end
      end
      e.cout = c[0];
    end
    return e;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: reset-state checks, idle adder-port checks, scoreboard on done, final tally
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk(busy == 1'b0 && done == 1'b0, "rst_busy_done", {30'd0, busy, done}, 32'd0);
      chk(sum == '0, "rst_sum", 32'(sum), 32'd0);
      chk(cout == 1'b0 && err == 1'b0, "rst_cout_err", {30'd0, cout, err}, 32'd0);
      chk({add_a, add_b, add_cin} == 9'd0, "rst_add_ports", 32'({add_a, add_b, add_cin}), 32'd0);
    end else begin
      if (!busy)
        chk({add_a, add_b, add_cin} == 9'd0, "idle_add_ports", 32'({add_a, add_b, add_cin}), 32'd0);
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_done", 32'(sum), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk(sum == e.sum, "sum", 32'(sum), 32'(e.sum));
          chk(cout == e.cout, "cout", 32'(cout), 32'(e.cout));
          chk(err == e.err, "err", 32'(err), 32'(e.err));
          chk(cyc == e.cyc, "done_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      if (fin_req) begin
        chk(timeouts == 0, "done_timeouts", 32'(timeouts), 32'd0);
        chk(q.size() == 0, "pending_results", 32'(q.size()), 32'd0);
        chk(done_cnt == exp_dones, "done_count", 32'(done_cnt), 32'(exp_dones));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge after done
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input bit poke);
    exp_t e;
    int   n;
    e = model(a, b, ci, sb);
    e.cyc = cyc + DIGITS + 1;
    q.push_back(e);
    exp_dones++;
    op_a = a; op_b = b; cin = ci; op_sub = sb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      op_a = rand_bcd(); op_b = rand_bcd(); cin = ~ci; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) timeouts++;
    @(negedge clk);
  endtask

  logic [W-1:0] ra, rb;
  logic         rs;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h4321, 16'h0789, 1'b1, 1'b0, 1'b1);
    run_op(16'h000A, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op(16'h0042, 16'h0017, 1'b0, 1'b0, 1'b0);

    // Abandon an operation with reset just after a clock edge
    op_a = 16'h5555; op_b = 16'h4444; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(16'h0808, 16'h0909, 1'b0, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
    run_op(16'h5000, 16'h1234, 1'b0, 1'b1, 1'b0);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(5) == 0) ra[4*$urandom_range(DIGITS-1) +: 4] = 4'($urandom_range(15, 10));
      if ($urandom_range(7) == 0) rb[4*$urandom_range(DIGITS-1) +: 4] = 4'($urandom_range(15, 10));
`ifdef BCD_SUB_EN
      rs = 1'($urandom_range(1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, 1'($urandom_range(1)), rs, 1'b0);
    end

    fin_req = 1;
    repeat (5) @(negedge clk);
    $display("FAIL summary_not_reached actual=0 required=1");
    $fatal(1);
  end

endmodule
